// File: rtl/arima_diff.sv
// arima_diff: d-th order differencing stage feeding the ARMA core.
// Each accepted sample x[n] runs through a cascade t0 = x, tk = t(k-1) - hist[k-1],
// and the latest difference of every order is kept in hist so a downstream
// integrator can be seeded to undo the differencing bit-exactly.
// Optional feature macro: ARIMA_DIFF_SNAPSHOT_EN drives snap/snap_valid from the
// difference history; without it both are tied to zero and the ports remain.
// Handshake: a beat moves on a port in any cycle where valid && ready are both
// high at the rising edge; valid never depends on ready, and out_data/out_valid
// hold while out_valid && !out_ready.
module arima_diff #(
  parameter int DATA_W = 32,
  parameter int MAX_D  = 9
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic [3:0]                     d_order,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [DATA_W-1:0]       in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [DATA_W-1:0]       out_data,
  output logic [MAX_D:0][DATA_W-1:0]     snap,
  output logic                           snap_valid,
  output logic                           dbg_state
);

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

  localparam logic [3:0] MAX_D_L = 4'(MAX_D);

  state_t                         state;
  logic [MAX_D:0][DATA_W-1:0]     hist;
  logic [MAX_D:0][DATA_W-1:0]     t;
  logic [DATA_W-1:0]              t_sel;
  logic [3:0]                     cnt;
  logic [3:0]                     d_lat;
  logic                           d_held;
  logic [3:0]                     d_cap;
  logic [3:0]                     d_eff;
  logic                           accept;
  logic                           fill_done;

  // Ready depends only on registered state and the consumer, never on in_data.
  assign in_ready  = !clear && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign dbg_state = state;

  // Order in force: the latched one once captured, otherwise the clamped request.
  always_comb begin
    d_cap = (d_order > MAX_D_L) ? MAX_D_L : d_order;
    d_eff = d_held ? d_lat : d_cap;
  end

  // Difference cascade on the incoming sample against the previous history.
  always_comb begin
    t     = '0;
    t[0]  = in_data;
    for (int k = 1; k <= MAX_D; k++) begin
      t[k] = t[k-1] - hist[k-1];
    end
    t_sel = '0;
    for (int k = 0; k <= MAX_D; k++) begin
      if (k == int'(d_eff)) t_sel = t[k];
    end
  end

  // The history is complete once cnt reaches the order; that accept emits first.
  assign fill_done = (cnt == d_eff);

  // Control FSM, history registers and the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      hist      <= '0;
      cnt       <= '0;
      d_lat     <= '0;
      d_held    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clear) begin
      state     <= FILL;
      hist      <= '0;
      cnt       <= '0;
      d_lat     <= '0;
      d_held    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      d_held <= 1'b1;
      d_lat  <= d_eff;
      for (int k = 0; k <= MAX_D; k++) begin
        if (k <= int'(d_eff)) hist[k] <= t[k];
      end
      case (state)
        FILL: begin
          if (fill_done) begin
            out_valid <= 1'b1;
            out_data  <= t_sel;
            state     <= RUN;
          end else begin
            cnt <= cnt + 4'd1;
            if (out_ready) out_valid <= 1'b0;
          end
        end
        RUN: begin
          out_valid <= 1'b1;
          out_data  <= t_sel;
        end
        default: state <= FILL;
      endcase
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ARIMA_DIFF_SNAPSHOT_EN
  logic snap_pulse;

  // One-cycle pulse after the edge that completes the history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_pulse <= 1'b0;
    end else if (clear) begin
      snap_pulse <= 1'b0;
    end else begin
      snap_pulse <= accept && (state == FILL) && fill_done;
    end
  end

  assign snap       = hist;
  assign snap_valid = snap_pulse;
`else
  assign snap       = '0;
  assign snap_valid = 1'b0;
`endif

endmodule

// File: tb/tb_arima_diff.sv
// tb_arima_diff: directed and random stimulus for arima_diff with a queue
// scoreboard. Expected differences come from the binomial form
// sum_j (-1)^j C(d,j) x[n-j] over the accepted samples since the last flush.
module tb_arima_diff;
  localparam int DW = 32;
  localparam int MD = 9;
`ifdef ARIMA_DIFF_SNAPSHOT_EN
  localparam bit SNAP_EN = 1'b1;
`else
  localparam bit SNAP_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 clear = 1'b0;
  logic [3:0]           d_order = 4'd0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [DW-1:0]        in_data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [DW-1:0]        out_data;
  logic [MD:0][DW-1:0]  snap;
  logic                 snap_valid;
  logic                 dbg_state;

  arima_diff #(.DATA_W(DW), .MAX_D(MD)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .d_order(d_order),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .snap(snap), .snap_valid(snap_valid), .dbg_state(dbg_state)
  );

  // scoreboard and reference state
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] x_q[$];
  bit m_ov   = 1'b0;
  bit m_sv   = 1'b0;
  bit m_held = 1'b0;
  int m_d    = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] diff_k(input int k);
    logic [DW-1:0] acc;
    logic [DW-1:0] cc;
    int c;
    int n;
    acc = '0;
    c = 1;
    n = x_q.size() - 1;
    for (int j = 0; j <= k; j++) begin
      cc = c;
      if ((j % 2) == 0) acc = acc + cc * x_q[n-j];
      else              acc = acc - cc * x_q[n-j];
      c = c * (k - j) / (j + 1);
    end
    return acc;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    x_q.delete();
    m_ov = 1'b0;
    m_sv = 1'b0;
    m_held = 1'b0;
    m_d = 0;
  endtask

  task automatic check_snap();
    logic [DW-1:0] e;
    if (x_q.size() == 0) begin
      for (int k = 0; k <= MD; k++) chk($sformatf("snap%0d_zero", k), snap[k], '0);
    end else if (x_q.size() > m_d) begin
      for (int k = 0; k <= MD; k++) begin
        e = (SNAP_EN && k <= m_d) ? diff_k(k) : '0;
        chk($sformatf("snap%0d", k), snap[k], e);
      end
    end
  endtask

  // driver: one clock cycle of stimulus; checks the state left by the previous edge
  task automatic cycle(input bit v, input logic [DW-1:0] x, input bit ordy, input bit clr,
                       output bit acc);
    bit exp_rdy;
    bit m_run;
    int n;
    @(negedge clk);
    in_valid = v;
    in_data = x;
    out_ready = ordy;
    clear = clr;
    #1;
    m_run = m_held && (x_q.size() > m_d);
    chk("out_valid", out_valid, m_ov);
    chk("snap_valid", snap_valid, m_sv & SNAP_EN);
    chk("fsm_state", dbg_state, m_run);
    exp_rdy = !clr && (!m_ov || ordy);
    chk("in_ready", in_ready, exp_rdy);
    if (m_ov) begin
      chk("scoreboard_nonempty", (exp_q.size() > 0), 1'b1);
      if (exp_q.size() > 0) begin
        chk("out_data", out_data, exp_q[0]);
        if (ordy) void'(exp_q.pop_front());
      end
    end
    check_snap();
    acc = v && exp_rdy;
    m_sv = 1'b0;
    if (clr) begin
      model_reset();
    end else if (acc) begin
      if (!m_held) begin
        m_d = (int'(d_order) > MD) ? MD : int'(d_order);
        m_held = 1'b1;
      end
      x_q.push_back(x);
      n = x_q.size() - 1;
      if (n >= m_d) begin
        exp_q.push_back(diff_k(m_d));
        m_ov = 1'b1;
        m_sv = (n == m_d);
      end else if (ordy) begin
        m_ov = 1'b0;
      end
    end else if (ordy) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic send(input logic [DW-1:0] x);
    bit acc;
    int tries;
    tries = 0;
    acc = 1'b0;
    while (!acc && tries < 20) begin
      cycle(1'b1, x, 1'b1, 1'b0, acc);
      tries++;
    end
    chk("send_accepted", acc, 1'b1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, 1'b0, acc);
  endtask

  task automatic flush();
    bit acc;
    cycle(1'b0, '0, 1'b1, 1'b1, acc);
  endtask

  // directed sequence
  initial begin
    bit acc;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    chk("reset_out_data", out_data, '0);
    idle(1);

    // order 1: 5 8 12 11 -> 3 4 -1
    d_order = 4'd1;
    send(32'd5); send(32'd8); send(32'd12); send(32'd11);
    idle(2);

    // order 2: squares -> constant 2
    flush();
    d_order = 4'd2;
    send(32'd1); send(32'd4); send(32'd9); send(32'd16); send(32'd25);
    idle(2);

    // order 0 pass-through
    flush();
    d_order = 4'd0;
    send(32'd7); send(32'hFFFF_FFFD);
    idle(2);

    // order request above MAX_D clamps to MAX_D
    flush();
    d_order = 4'd15;
    for (int i = 0; i < 12; i++) send(32'($urandom_range(0, 1000)));
    idle(2);

    // wrap-around subtraction
    flush();
    d_order = 4'd1;
    send(32'h7FFF_FFFF); send(32'h8000_0000);
    idle(2);

    // backpressure: stall after the first output
    flush();
    d_order = 4'd1;
    send(32'd5); send(32'd8);
    repeat (5) cycle(1'b1, 32'd12, 1'b0, 1'b0, acc);
    send(32'd12); send(32'd11);

    // flush in RUN with a beat offered, then capture a new order
    send(32'd20);
    cycle(1'b1, 32'd99, 1'b1, 1'b1, acc);
    d_order = 4'd2;
    for (int i = 0; i < 6; i++) send($urandom());
    idle(2);

    // random traffic with random backpressure
    flush();
    d_order = 4'($urandom_range(0, 15));
    for (int i = 0; i < 80; i++)
      cycle(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)), 1'b0, acc);
    idle(3);

    // asynchronous reset mid-stream
    flush();
    d_order = 4'd2;
    for (int i = 0; i < 5; i++) send($urandom());
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_snap_valid", snap_valid, 1'b0);
    chk("rst_snap", snap, '0);
    chk("rst_fsm_state", dbg_state, 1'b0);
    in_valid = 1'b0;
    clear = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    d_order = 4'd3;
    for (int i = 0; i < 8; i++) send($urandom());
    idle(3);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
